// File: rtl/ibex_mem_arb_pkg.sv
// rtl/ibex_mem_arb_pkg.sv - shared owner and selection-state types for the ibex memory arbiter
package ibex_mem_arb_pkg;

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } arb_owner_e;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ibex_mem_arb_owner_fifo.sv
// rtl/ibex_mem_arb_owner_fifo.sv - in-order FIFO of granted-transaction owners
// Pointers wrap modulo Depth, so non-power-of-two depths are supported.
module ibex_mem_arb_owner_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_owner,
  input  logic                       i_pop,
  output logic                       o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  arb_owner_e      r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries need no reset: the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= arb_owner_e'(i_owner);
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - shares one OBI memory between ibex instruction and data ports
// IBEX_MEM_ARB_RR_EN selects round-robin arbitration; otherwise data has fixed priority.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                instr_req_i,
  input  logic [AddrWidth-1:0]                instr_addr_i,
  output logic                                instr_gnt_o,
  output logic                                instr_rvalid_o,
  output logic [DataWidth-1:0]                instr_rdata_o,
  output logic                                instr_err_o,
  input  logic                                data_req_i,
  input  logic                                data_we_i,
  input  logic [DataWidth/8-1:0]              data_be_i,
  input  logic [AddrWidth-1:0]                data_addr_i,
  input  logic [DataWidth-1:0]                data_wdata_i,
  output logic                                data_gnt_o,
  output logic                                data_rvalid_o,
  output logic [DataWidth-1:0]                data_rdata_o,
  output logic                                data_err_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [DataWidth/8-1:0]              mem_be_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [DataWidth-1:0]                mem_rdata_i,
  input  logic                                mem_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                spurious_rvalid_o
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_owner_e r_locked_owner;
  arb_owner_e w_locked_owner_nxt;
  arb_owner_e w_winner;
  arb_owner_e w_sel;
  logic       w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_grant;
  logic       w_pop;
  logic       w_sel_data;
  logic       r_spurious;

`ifdef IBEX_MEM_ARB_RR_EN
  arb_owner_e r_rr_ptr;

  // The pointer moves away from whoever was just granted, so a contender always gets the next slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= OwnerData;
    end else if (w_grant) begin
      r_rr_ptr <= (w_sel == OwnerData) ? OwnerInstr : OwnerData;
    end
  end

  always_comb begin
    w_winner = OwnerInstr;
    if (instr_req_i && data_req_i) w_winner = r_rr_ptr;
    else if (data_req_i)           w_winner = OwnerData;
  end
`else
  always_comb begin
    w_winner = data_req_i ? OwnerData : OwnerInstr;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ArbIdle;
      r_locked_owner <= OwnerInstr;
    end else begin
      r_state        <= w_state_nxt;
      r_locked_owner <= w_locked_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_locked_owner_nxt = r_locked_owner;
    case (r_state)
      ArbIdle: begin
        if (mem_req_o && !mem_gnt_i) begin
          w_state_nxt        = ArbLocked;
          w_locked_owner_nxt = w_winner;
        end
      end
      ArbLocked: begin
        if (mem_gnt_i) w_state_nxt = ArbIdle;
      end
      default: w_state_nxt = ArbIdle;
    endcase
  end

  assign w_sel      = (r_state == ArbLocked) ? r_locked_owner : w_winner;
  assign w_sel_data = (w_sel == OwnerData);

  // Full comes from the registered count, so a same-cycle pop cannot open a grant slot.
  assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full & ~rst_i;
  assign w_grant     = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = w_grant & ~w_sel_data;
  assign data_gnt_o  = w_grant & w_sel_data;

  assign mem_we_o    = w_sel_data & data_we_i;
  assign mem_be_o    = w_sel_data ? data_be_i : {(DataWidth/8){1'b1}};
  assign mem_addr_o  = w_sel_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = w_sel_data ? data_wdata_i : '0;

  ibex_mem_arb_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_grant),
    .i_owner (w_sel_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

  assign w_pop          = mem_rvalid_i & ~w_empty;
  assign instr_rvalid_o = w_pop & ~w_head;
  assign data_rvalid_o  = w_pop & w_head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_spurious <= 1'b0;
    end else if (mem_rvalid_i && w_empty) begin
      r_spurious <= 1'b1;
    end
  end

  assign spurious_rvalid_o = r_spurious;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - directed self-checking bench for ibex_mem_arbiter (fixed-priority build)
module tb_ibex_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic [1:0]  outstanding_o;
  logic        spurious_rvalid_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_mem_arbiter #(
    .MaxOutstanding (2),
    .AddrWidth      (32),
    .DataWidth      (32)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .instr_req_i       (instr_req_i),
    .instr_addr_i      (instr_addr_i),
    .instr_gnt_o       (instr_gnt_o),
    .instr_rvalid_o    (instr_rvalid_o),
    .instr_rdata_o     (instr_rdata_o),
    .instr_err_o       (instr_err_o),
    .data_req_i        (data_req_i),
    .data_we_i         (data_we_i),
    .data_be_i         (data_be_i),
    .data_addr_i       (data_addr_i),
    .data_wdata_i      (data_wdata_i),
    .data_gnt_o        (data_gnt_o),
    .data_rvalid_o     (data_rvalid_o),
    .data_rdata_o      (data_rdata_o),
    .data_err_o        (data_err_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_be_o          (mem_be_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i),
    .mem_err_i         (mem_err_i),
    .outstanding_o     (outstanding_o),
    .spurious_rvalid_o (spurious_rvalid_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic quiet;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    mem_err_i    = 1'b0;
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1ns later.
  task automatic next_cyc;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i        = 1'b1;
    instr_addr_i = 32'h0001_0000;
    data_addr_i  = 32'h0000_2000;
    data_wdata_i = 32'h0;
    quiet();
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    #2;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_instr_gnt", instr_gnt_o, 0);
    check("rst_data_gnt", data_gnt_o, 0);
    check("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_spurious", spurious_rvalid_o, 0);
    quiet();
    #1;
    check("idle_addr_instr", mem_addr_o, 32'h0001_0000);
    check("idle_we", mem_we_o, 0);
    check("idle_be", mem_be_o, 4'hF);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Both request with grant: data wins under fixed priority.
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    #1;
    check("both_data_gnt", data_gnt_o, 1);
    check("both_instr_gnt", instr_gnt_o, 0);
    check("both_addr", mem_addr_o, 32'h0000_2000);
    next_cyc();
    quiet();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
    #1;
    check("t1_outstanding", outstanding_o, 1);
    check("t1_data_rvalid", data_rvalid_o, 1);
    check("t1_instr_rvalid", instr_rvalid_o, 0);
    check("t1_data_rdata", data_rdata_o, 32'h11);
    next_cyc();
    quiet();

    // Instruction request held ungranted; data request arriving later must not steal the port.
    instr_req_i = 1'b1;
    #1;
    check("lock_addr_c1", mem_addr_o, 32'h0001_0000);
    next_cyc();
    data_req_i = 1'b1;
    #1;
    check("lock_addr_c2", mem_addr_o, 32'h0001_0000);
    check("lock_no_gnt", data_gnt_o, 0);
    next_cyc();
    #1;
    check("lock_addr_c3", mem_addr_o, 32'h0001_0000);
    next_cyc();
    mem_gnt_i = 1'b1;
    #1;
    check("lock_instr_gnt", instr_gnt_o, 1);
    check("lock_data_gnt0", data_gnt_o, 0);
    next_cyc();
    instr_req_i = 1'b0;
    #1;
    check("after_lock_data_gnt", data_gnt_o, 1);
    check("after_lock_addr", mem_addr_o, 32'h0000_2000);
    next_cyc();

    // FIFO now holds {instr, data}: full blocks requests even with a same-cycle pop.
    data_req_i = 1'b0; instr_req_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA;
    #1;
    check("full_outstanding", outstanding_o, 2);
    check("full_mem_req", mem_req_o, 0);
    check("full_instr_gnt", instr_gnt_o, 0);
    check("ordA_instr_rvalid", instr_rvalid_o, 1);
    check("ordA_data_rvalid", data_rvalid_o, 0);
    check("ordA_rdata", instr_rdata_o, 32'hA);
    next_cyc();
    mem_rdata_i = 32'hB;
    #1;
    check("resume_outstanding", outstanding_o, 1);
    check("resume_instr_gnt", instr_gnt_o, 1);
    check("ordB_data_rvalid", data_rvalid_o, 1);
    check("ordB_instr_rvalid", instr_rvalid_o, 0);
    check("ordB_rdata", data_rdata_o, 32'hB);
    next_cyc();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'hC;
    #1;
    check("pushpop_outstanding", outstanding_o, 1);
    check("ordC_instr_rvalid", instr_rvalid_o, 1);
    check("ordC_data_rvalid", data_rvalid_o, 0);
    check("ordC_rdata", instr_rdata_o, 32'hC);
    next_cyc();
    quiet();
    #1;
    check("drained_outstanding", outstanding_o, 0);

    // Data store with byte enables, then an error response.
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
    data_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1'b1;
    #1;
    check("st_gnt", data_gnt_o, 1);
    check("st_we", mem_we_o, 1);
    check("st_be", mem_be_o, 4'b0011);
    check("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    next_cyc();
    quiet();
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
    #1;
    check("st_rvalid", data_rvalid_o, 1);
    check("st_err", data_err_o, 1);
    check("st_instr_rvalid", instr_rvalid_o, 0);
    next_cyc();
    quiet();

    // Response with nothing outstanding.
    mem_rvalid_i = 1'b1;
    #1;
    check("sp_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    check("sp_before", spurious_rvalid_o, 0);
    next_cyc();
    quiet();
    #1;
    check("sp_set", spurious_rvalid_o, 1);
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    next_cyc();
    quiet();
    #1;
    check("sp_held", spurious_rvalid_o, 1);
    check("mid_outstanding", outstanding_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_outstanding", outstanding_o, 0);
    check("arst_spurious", spurious_rvalid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    check("post_rst_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    next_cyc();
    quiet();
    #1;
    check("post_rst_spurious", spurious_rvalid_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
